// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-stage signals of the sub-word load/store sequencer.
// The slave modport is the sequencer; master is the execute stage plus memory stage.
interface mem_access_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] load_data;
  logic        Mem_WrEn;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic [31:0] MEM_DataOut;

  modport master (
    output start, op, addr, store_data, MEM_DataOut,
    input  busy, done, misaligned, load_data, Mem_WrEn, MEM_Addr, MEM_DataIn
  );

  modport slave (
    input  start, op, addr, store_data, MEM_DataOut,
    output busy, done, misaligned, load_data, Mem_WrEn, MEM_Addr, MEM_DataIn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sub-word load/store sequencer in front of a word-only, big-endian data memory.
// Byte/halfword stores are performed as read-modify-write of the containing word.
module mem_access_ctrl (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, LOAD, MERGE, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        misaligned_q;
  logic [31:0] load_data_q;
  logic        capture;

  function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] a);
    case (o)
      OP_LW, OP_SW:         is_misaligned = |a;
      OP_LH, OP_LHU, OP_SH: is_misaligned = a[0];
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] o, input logic [1:0] off,
                                              input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (o)
      OP_LB:   extend_load = 32'(b);
      OP_LBU:  extend_load = {24'd0, b};
      OP_LH:   extend_load = 32'(h);
      OP_LHU:  extend_load = {16'd0, h};
      default: extend_load = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [2:0] o, input logic [1:0] off,
                                              input logic [31:0] w, input logic [31:0] d);
    merge_store = w;
    if (o == OP_SB) begin
      case (off)
        2'd0:    merge_store[31:24] = d[7:0];
        2'd1:    merge_store[23:16] = d[7:0];
        2'd2:    merge_store[15:8]  = d[7:0];
        default: merge_store[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      merge_store[15:0] = d[15:0];
    end else begin
      merge_store[31:16] = d[15:0];
    end
  endfunction

  assign capture = (state == IDLE) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_misaligned(bus.op, bus.addr[1:0])) state_nxt = DONE;
          else if (bus.op == OP_SW)                 state_nxt = WRITE;
          else                                      state_nxt = READ;
        end
      end
      READ:    state_nxt = (op_q <= OP_LHU) ? LOAD : MERGE;
      LOAD:    state_nxt = DONE;
      MERGE:   state_nxt = DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registers visible on the outputs are cleared by reset; the rest only load on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      misaligned_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      if (capture) begin
        addr_q       <= bus.addr;
        misaligned_q <= is_misaligned(bus.op, bus.addr[1:0]);
      end
      if (state == LOAD)
        load_data_q <= extend_load(op_q, addr_q[1:0], bus.MEM_DataOut);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      op_q   <= bus.op;
      data_q <= bus.store_data;
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.misaligned = (state == DONE) && misaligned_q;
  assign bus.load_data  = load_data_q;
  assign bus.Mem_WrEn   = (state == WRITE) || (state == MERGE);
  assign bus.MEM_Addr   = {addr_q[31:2], 2'b00};

  always_comb begin
    bus.MEM_DataIn = '0;
    if (state == WRITE)
      bus.MEM_DataIn = data_q;
    else if (state == MERGE)
      bus.MEM_DataIn = merge_store(op_q, addr_q[1:0], bus.MEM_DataOut, data_q);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered-read word memory model.
module tb_mem_access_ctrl;
  localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011;
  localparam logic [2:0] LHU = 3'b100, SW = 3'b101, SB = 3'b110, SH = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();
  mem_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.Mem_WrEn) mem[bus.MEM_Addr[7:2]] <= bus.MEM_DataIn;
    bus.MEM_DataOut <= mem[bus.MEM_Addr[7:2]];
  end

  int checks = 0;
  int fails  = 0;
  int lat, wrs, rds;
  logic mis, after_busy;
  logic [31:0] wdata;

  // Issues one request and observes it until done (10-cycle bound; lat=99 if it never completes).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        input bit pulse);
    @(negedge clk);
    bus.op = o; bus.addr = a; bus.store_data = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 99; wrs = 0; rds = 0; mis = 1'b0; wdata = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.Mem_WrEn) begin wrs++; wdata = bus.MEM_DataIn; end
      if (bus.busy && !bus.done && !bus.Mem_WrEn) rds++;
      if (bus.done) begin lat = k; mis = bus.misaligned; bus.start = 1'b0; break; end
      if (pulse) begin bus.start = 1'b1; bus.op = SW; bus.addr = 32'h40; bus.store_data = 32'h55; end
    end
    @(negedge clk);
    after_busy = bus.done || bus.busy || bus.misaligned;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.op = LW; bus.addr = '0; bus.store_data = '0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.misaligned, bus.Mem_WrEn} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 0000",
                        {bus.busy, bus.done, bus.misaligned, bus.Mem_WrEn});
    end
    checks++;
    if ({bus.load_data, bus.MEM_Addr, bus.MEM_DataIn} !== 96'd0) begin
      fails++; $display("FAIL reset_data: load %h addr %h din %h required all 0",
                        bus.load_data, bus.MEM_Addr, bus.MEM_DataIn);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_sw_lw();
    run_op(SW, 32'h10, 32'hDEADBEEF, 1'b0);
    checks++; if (lat !== 2) begin fails++; $display("FAIL sw_latency: got %0d required 2", lat); end
    checks++; if (wrs !== 1) begin fails++; $display("FAIL sw_wren_cycles: got %0d required 1", wrs); end
    checks++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata: got %h required deadbeef", wdata); end
    checks++; if (mis !== 1'b0) begin fails++; $display("FAIL sw_misaligned: got %b required 0", mis); end
    checks++; if (after_busy !== 1'b0) begin fails++; $display("FAIL sw_done_width: got %b required 0", after_busy); end
    run_op(LW, 32'h10, 32'h0, 1'b0);
    checks++; if (lat !== 3) begin fails++; $display("FAIL lw_latency: got %0d required 3", lat); end
    checks++; if (bus.load_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h required deadbeef", bus.load_data); end
    checks++; if (wrs !== 0) begin fails++; $display("FAIL lw_no_write: got %0d required 0", wrs); end
    checks++; if (bus.MEM_Addr !== 32'h10) begin fails++; $display("FAIL lw_addr_hold: got %h required 00000010", bus.MEM_Addr); end
  endtask

  task automatic test_sb_rmw();
    run_op(SW, 32'h20, 32'h11223344, 1'b0);
    run_op(SB, 32'h21, 32'h123456AA, 1'b0);
    checks++; if (rds !== 1) begin fails++; $display("FAIL sb_reads: got %0d required 1", rds); end
    checks++; if (wrs !== 1) begin fails++; $display("FAIL sb_writes: got %0d required 1", wrs); end
    checks++; if (wdata !== 32'h11AA3344) begin fails++; $display("FAIL sb_merge: got %h required 11aa3344", wdata); end
    checks++; if (lat !== 3) begin fails++; $display("FAIL sb_latency: got %0d required 3", lat); end
    checks++; if (bus.load_data !== 32'hDEADBEEF) begin fails++; $display("FAIL sb_keeps_load: got %h required deadbeef", bus.load_data); end
    run_op(LW, 32'h20, 32'h0, 1'b0);
    checks++; if (bus.load_data !== 32'h11AA3344) begin fails++; $display("FAIL sb_readback: got %h required 11aa3344", bus.load_data); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  ops  [7] = '{LB, LBU, LB, LH, LB, LBU, LHU};
    logic [31:0] adrs [7] = '{32'h30, 32'h30, 32'h32, 32'h32, 32'h31, 32'h33, 32'h30};
    logic [31:0] exps [7] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h00007F01,
                              32'hFFFFFFFF, 32'h00000001, 32'h000080FF};
    run_op(SW, 32'h30, 32'h80FF7F01, 1'b0);
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], adrs[i], 32'h0, 1'b0);
      checks++;
      if (bus.load_data !== exps[i] || lat !== 3) begin
        fails++; $display("FAIL load_ext[%0d]: got %h lat %0d required %h lat 3",
                          i, bus.load_data, lat, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops  [3] = '{LH, SW, LW};
    logic [31:0] adrs [3] = '{32'h31, 32'h22, 32'h32};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], adrs[i], 32'hCAFEF00D, 1'b0);
      checks++;
      if (lat !== 1 || mis !== 1'b1 || wrs !== 0) begin
        fails++; $display("FAIL misaligned[%0d]: got lat %0d mis %b wr %0d required lat 1 mis 1 wr 0",
                          i, lat, mis, wrs);
      end
      checks++;
      if (bus.load_data !== 32'h000080FF || after_busy !== 1'b0) begin
        fails++; $display("FAIL misaligned_keep[%0d]: got load %h after %b required 000080ff 0",
                          i, bus.load_data, after_busy);
      end
    end
  endtask

  task automatic test_sh_busy_pulses();
    run_op(SW, 32'h20, 32'h11223344, 1'b0);
    run_op(SH, 32'h22, 32'h0000BEEF, 1'b1);
    checks++; if (lat !== 3 || wrs !== 1) begin fails++; $display("FAIL sh_timing: got lat %0d wr %0d required 3 1", lat, wrs); end
    checks++; if (wdata !== 32'h1122BEEF) begin fails++; $display("FAIL sh_merge: got %h required 1122beef", wdata); end
    repeat (3) @(negedge clk);
    checks++;
    if (after_busy !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL sh_single_op: got after %b busy %b done %b required 0 0 0",
                        after_busy, bus.busy, bus.done);
    end
    checks++; if (mem[8] !== 32'h1122BEEF) begin fails++; $display("FAIL sh_memory: got %h required 1122beef", mem[8]); end
  endtask

  task automatic test_reset_mid_merge();
    @(negedge clk);
    bus.op = SB; bus.addr = 32'h21; bus.store_data = 32'h77; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #2;
    checks++; if (bus.Mem_WrEn !== 1'b1) begin fails++; $display("FAIL merge_reached: got %b required 1", bus.Mem_WrEn); end
    rst = 1'b1;
    #1;
    checks++; if (bus.Mem_WrEn !== 1'b0) begin fails++; $display("FAIL rst_wren_async: got %b required 0", bus.Mem_WrEn); end
    checks++;
    if ({bus.busy, bus.done, bus.misaligned} !== 3'b0 ||
        {bus.load_data, bus.MEM_Addr, bus.MEM_DataIn} !== 96'd0) begin
      fails++; $display("FAIL rst_outputs: busy %b done %b mis %b load %h addr %h din %h required all 0",
                        bus.busy, bus.done, bus.misaligned, bus.load_data, bus.MEM_Addr, bus.MEM_DataIn);
    end
    @(posedge clk); @(negedge clk); rst = 1'b0;
    checks++; if (mem[8] !== 32'h1122BEEF) begin fails++; $display("FAIL rst_mem_intact: got %h required 1122beef", mem[8]); end
    run_op(LW, 32'h20, 32'h0, 1'b0);
    checks++;
    if (lat !== 3 || bus.load_data !== 32'h1122BEEF) begin
      fails++; $display("FAIL post_rst_lw: got lat %0d data %h required 3 1122beef", lat, bus.load_data);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_load_extend();
    test_misaligned();
    test_sh_busy_pulses();
    test_reset_mid_merge();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sub-word load/store sequencer between the execute stage and the word-wide data memory stage. It takes one memory operation per request: LW, LB, LBU, LH, LHU, SW, SB or SH. It drives the memory stage's write enable, address and write data, and returns an aligned, extended load result with a completion pulse. Byte and halfword stores are done as read-modify-write, because the data memory only supports whole 32-bit words.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock, shared with the memory stage.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  operation code:
  - 000 LW, 001 LB, 010 LBU, 011 LH
  - 100 LHU, 101 SW, 110 SB, 111 SH
- addr  input  32  byte address from the ALU.
- store_data  input  32  store operand; the byte or halfword is taken from the low bits.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  valid with done; 1 means the request was rejected.
- load_data  output  32  extended load result; holds until the next successful load.
- Mem_WrEn  output  1  memory write enable.
- MEM_Addr  output  32  word address, {addr_q[31:2], 2'b00}.
- MEM_DataIn  output  32  memory write data.
- MEM_DataOut  input  32  memory read data; registered in the memory stage and valid the cycle after the read edge.

## Operation
- Request capture: in IDLE, with start=1 at a rising edge, the block latches op_q, addr_q and data_q. start is ignored in any other state.
- Alignment rules:
  - LW/SW need addr[1:0]=00.
  - LH/LHU/SH need addr[0]=0.
  - Byte operations are always aligned.
- Byte order is big-endian:
  - Byte offset 0 is bits [31:24] and offset 3 is bits [7:0].
  - Halfword offset 0 is bits [31:16] and offset 2 is bits [15:0].
- State machine transitions:
  - IDLE -> DONE on a misaligned request; misaligned_q=1.
  - IDLE -> WRITE on an aligned SW.
  - IDLE -> READ on any aligned load, SB or SH.
  - READ -> LOAD for loads; READ -> MERGE for SB/SH.
  - LOAD -> DONE; MERGE -> DONE; WRITE -> DONE.
  - DONE -> IDLE.
- State behaviour:
  - READ: Mem_WrEn=0 and MEM_Addr valid; the memory samples on the closing edge.
  - LOAD: selects the byte or halfword from MEM_DataOut and extends it. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through. load_data is registered at the closing edge.
  - MERGE: Mem_WrEn=1. MEM_DataIn is MEM_DataOut with the addressed byte (SB, data_q[7:0]) or halfword (SH, data_q[15:0]) replaced; all other bits are unchanged.
  - WRITE: Mem_WrEn=1 and MEM_DataIn=data_q.
  - DONE: done=1 and misaligned=misaligned_q.
- Mem_WrEn is high only in WRITE and MERGE. A misaligned request never writes memory and never changes load_data.
- Stores never change load_data.
- MEM_Addr and MEM_DataIn hold their values outside active states. MEM_DataIn is 0 except in WRITE/MERGE.

## Timing
Latency is counted from the start-sampling edge E0 to the cycle in which done is high:
- Misaligned: 1 cycle (done in E0->E1).
- SW: 2 cycles.
- Loads, SB and SH: 3 cycles.

Cycle-level rules:
- The next request can be sampled at the edge that closes DONE + 1, i.e. once back in IDLE. Back-to-back throughput is latency + 1.
- done is high for exactly one cycle. misaligned is 0 whenever done=0.
- A read issued in READ is never overlapped with a write. MERGE uses MEM_DataOut from the immediately preceding READ edge.
- Asynchronous reset, at any time including mid-operation:
  - state=IDLE and Mem_WrEn=0 immediately.
  - busy=0, done=0, misaligned=0.
  - load_data=0, MEM_Addr=0, MEM_DataIn=0.
- An SB/SH interrupted by reset before the MERGE edge leaves memory unmodified.
- start held high continuously issues a new request each time the block is in IDLE; there is no edge detection.

## Test plan
1. SW 0xDEADBEEF at addr 0x10, then LW at 0x10:
   - SW: done 2 cycles after start, Mem_WrEn high for exactly 1 cycle.
   - LW: load_data=0xDEADBEEF, done 3 cycles after start.
2. With word 0x11223344 at 0x20, SB data 0xAA at 0x21, then LW at 0x20:
   - Store: exactly one read, then one write of 0x11AA3344.
   - Load: load_data=0x11AA3344.
3. With word 0x80FF7F01 at 0x30:
   - LB at 0x30 -> 0xFFFFFF80.
   - LBU at 0x30 -> 0x00000080.
   - LB at 0x32 -> 0x0000007F.
   - LH at 0x32 -> 0x00007F01.
   - LHU at 0x30 -> 0x000080FF.
4. Misaligned requests:
   - LH at 0x31: done after 1 cycle with misaligned=1, Mem_WrEn never high, load_data unchanged.
   - SW at 0x22: same behaviour as LH at 0x31.
5. SH 0xBEEF at 0x22 over 0x11223344 -> memory holds 0x1122BEEF. start pulses asserted while busy are ignored; exactly one operation completes.
6. Assert rst during MERGE of an SB:
   - Mem_WrEn drops asynchronously and the target word is unchanged.
   - All outputs take their reset values.
   - The next LW after reset completes normally.
